// File: rtl/hs_byte_aligner_pkg.sv
// Shared types and helpers for the HS byte aligner slice.
// Optional feature macro: HS_ALIGNER_TOL_EN (accept sync with one flipped bit).
package hs_align_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    LOCKED
  } state_t;

  typedef logic [2:0] offset_t;

  localparam logic [7:0] HS_SYNC_DEFAULT = 8'hB8;

  // True when a and b differ in exactly one bit position.
  function automatic logic one_bit_off(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = a ^ b;
    return (diff != 8'h00) && ((diff & (diff - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/hs_sync_match.sv
// Combinational sync-byte search over the eight bit offsets of a 16-bit history.
// With HS_ALIGNER_TOL_EN defined a window one bit away from the pattern also
// counts, but an exact match at any offset always wins.
module hs_sync_match
  import hs_align_pkg::*;
(
  input  logic [15:0] hist,
  input  logic [7:0]  pattern,
  output logic        hit,
  output logic [2:0]  offset
`ifdef HS_ALIGNER_TOL_EN
  ,
  output logic        exact
`endif
);

  logic    exact_hit;
  offset_t exact_off;

  // The top history bit never falls inside a window; keep lint quiet about it.
  logic unused_hist_msb;
  assign unused_hist_msb = hist[15];

  // Scan from the highest offset down so the lowest matching offset is kept.
  always_comb begin
    exact_hit = 1'b0;
    exact_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (hist[k +: 8] == pattern) begin
        exact_hit = 1'b1;
        exact_off = 3'(k);
      end
    end
  end

`ifdef HS_ALIGNER_TOL_EN
  logic    near_hit;
  offset_t near_off;

  // Same lowest-offset scan, but for windows at Hamming distance one.
  always_comb begin
    near_hit = 1'b0;
    near_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (one_bit_off(hist[k +: 8], pattern)) begin
        near_hit = 1'b1;
        near_off = 3'(k);
      end
    end
  end

  assign hit    = exact_hit | near_hit;
  assign offset = exact_hit ? exact_off : near_off;
  assign exact  = exact_hit;
`else
  assign hit    = exact_hit;
  assign offset = exact_off;
`endif

endmodule

// File: rtl/hs_byte_aligner.sv
// Per-lane D-PHY HS byte aligner: hunts for the sync byte in the raw
// deserializer words, latches the bit offset and then emits aligned bytes
// until hs_en drops. HS_ALIGNER_TOL_EN enables one-bit-error sync tolerance.
module hs_byte_aligner
  import hs_align_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = HS_SYNC_DEFAULT,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       hs_en,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       locked,
  output logic [2:0] bit_offset,
  output logic       sync_err
);

  localparam int             CW           = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    prev;
  logic [CW-1:0] miss_count;
  logic          primed;
  logic [15:0]   hist;
  logic          match_hit;
  offset_t       match_off;

  assign hist = {in_data, prev};

  hs_sync_match u_match (
    .hist    (hist),
    .pattern (SYNC_BYTE),
    .hit     (match_hit),
    .offset  (match_off)
`ifdef HS_ALIGNER_TOL_EN
    ,
    .exact   (unused_exact)
`endif
  );

`ifdef HS_ALIGNER_TOL_EN
  // Exact/near distinction is only informational at this level.
  logic unused_exact;
`endif

  // Alignment FSM with history, hunt timeout counter and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      prev       <= 8'h00;
      miss_count <= '0;
      primed     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      locked     <= 1'b0;
      bit_offset <= '0;
      sync_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (!hs_en) begin
        state      <= IDLE;
        prev       <= 8'h00;
        miss_count <= '0;
        primed     <= 1'b0;
        locked     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= HUNT;
          end
          HUNT: begin
            if (in_valid) begin
              prev   <= in_data;
              primed <= 1'b1;
              if (primed) begin
                if (match_hit) begin
                  state      <= LOCKED;
                  locked     <= 1'b1;
                  bit_offset <= match_off;
                  miss_count <= '0;
                end else if (miss_count == TIMEOUT_LAST) begin
                  sync_err   <= 1'b1;
                  miss_count <= '0;
                end else begin
                  miss_count <= miss_count + 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (in_valid) begin
              prev      <= in_data;
              out_valid <= 1'b1;
              out_data  <= hist[bit_offset +: 8];
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_byte_aligner.sv
// Self-checking bench for hs_byte_aligner: directed test-plan streams plus
// randomized packets, all checked against a serial-bitstream reference model.
module tb_hs_byte_aligner;

  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SYNC    = 8'hB8;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       hs_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       locked;
  logic [2:0] bit_offset;
  logic       sync_err;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: accepted serial bits, in arrival order.
  bit         mBits[$];
  int         mMode = 0;
  int         mMisses = 0;
  logic       mValid = 1'b0;
  logic [7:0] mData = 8'h00;
  logic       mLocked = 1'b0;
  logic [2:0] mOff = 3'd0;
  logic       mErr = 1'b0;

  hs_byte_aligner #(
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .hs_en      (hs_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .locked     (locked),
    .bit_offset (bit_offset),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBits.delete();
    mMode = 0;
    mMisses = 0;
    mValid = 1'b0;
    mData = 8'h00;
    mLocked = 1'b0;
    mOff = 3'd0;
    mErr = 1'b0;
  endtask

  // Lowest offset into the 16 buffered bits where the sync byte starts, or -1.
  function automatic int findSync();
    logic [7:0] win;
    int best = -1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) win[i] = mBits[k + i];
      if (win == SYNC && best < 0) best = k;
    end
`ifdef HS_ALIGNER_TOL_EN
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) win[i] = mBits[k + i];
      if ($countones(win ^ SYNC) == 1 && best < 0) best = k;
    end
`endif
    return best;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic hs, input logic v, input logic [7:0] d);
    int k;
    mValid = 1'b0;
    mErr = 1'b0;
    if (!hs) begin
      mMode = 0;
      mLocked = 1'b0;
      mMisses = 0;
      mBits.delete();
    end else if (mMode == 0) begin
      mMode = 1;
    end else if (v) begin
      for (int i = 0; i < 8; i++) mBits.push_back(d[i]);
      if (mMode == 1 && mBits.size() == 16) begin
        k = findSync();
        if (k >= 0) begin
          mMode = 2;
          mLocked = 1'b1;
          mOff = 3'(k);
          for (int i = 0; i < k + 8; i++) void'(mBits.pop_front());
        end else begin
          for (int i = 0; i < 8; i++) void'(mBits.pop_front());
          mMisses++;
          if (mMisses == TIMEOUT) begin
            mErr = 1'b1;
            mMisses = 0;
          end
        end
      end else if (mMode == 2) begin
        for (int i = 0; i < 8; i++) mData[i] = mBits.pop_front();
        mValid = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 8'(out_valid), 8'(mValid));
    checkOutput("out_data", out_data, mData);
    checkOutput("locked", 8'(locked), 8'(mLocked));
    checkOutput("bit_offset", 8'(bit_offset), 8'(mOff));
    checkOutput("sync_err", 8'(sync_err), 8'(mErr));
  endtask

  task automatic applyStimulus(input logic hs, input logic v, input logic [7:0] d);
    hs_en = hs;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    modelStep(hs, v, d);
    #1;
    checkAll();
  endtask

  // Builds a serial stream (preamble, sync, payload), packs it LSB-first into
  // words and sends it after returning the lane to IDLE. gapPct>=100 means a
  // strict 1/0 in_valid pattern.
  task automatic sendStream(input int preBits, input bit zeroPre, input logic [7:0] syncVal,
                            input int nPayload, input int gapPct);
    bit         bits[$];
    logic [7:0] w;
    logic [7:0] b;
    applyStimulus(1'b0, 1'b1, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < preBits; i++) bits.push_back(zeroPre ? 1'b0 : 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) bits.push_back(syncVal[i]);
    for (int j = 0; j < nPayload; j++) begin
      b = 8'($urandom);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    end
    while (bits.size() % 8 != 0) bits.push_back(1'($urandom_range(0, 1)));
    while (bits.size() > 0) begin
      for (int i = 0; i < 8; i++) w[i] = bits.pop_front();
      if (gapPct >= 100) applyStimulus(1'b1, 1'b0, 8'($urandom));
      else for (int g = 0; g < 4 && $urandom_range(0, 99) < gapPct; g++)
        applyStimulus(1'b1, 1'b0, 8'($urandom));
      applyStimulus(1'b1, 1'b1, w);
    end
  endtask

  initial begin
    logic [7:0] words[5];
    modelReset();
    #3;
    checkAll();
    arst_n = 1'b1;
    #4;

    // Offset 3 with zero preamble, no gaps.
    sendStream(3, 1'b1, SYNC, 3, 0);
    // Offset 0 from the raw-word example, plus one word to flush 0x55.
    words[0] = 8'h00; words[1] = 8'hB8; words[2] = 8'hAA; words[3] = 8'h55; words[4] = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, words[i]);
    // Long zero hunt: two timeouts before the sync shows up.
    sendStream(33 * 8, 1'b1, SYNC, 2, 0);
    // Offset 5 with strictly alternating in_valid.
    sendStream(5, 1'b1, SYNC, 4, 100);
    // Drop hs_en mid-stream, then relock at offset 2.
    sendStream(2, 1'b1, SYNC, 3, 0);
    sendStream(2, 1'b1, SYNC, 4, 0);
    // Sync with its LSB flipped at offset 1.
    sendStream(1, 1'b1, 8'hB9, 20, 0);

    // Asynchronous reset while locked mid-packet.
    sendStream(6, 1'b1, SYNC, 3, 0);
    #2 arst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    #1 arst_n = 1'b1;

    // Randomized packets: noisy or zero preambles, occasional corrupted sync.
    for (int n = 0; n < 40; n++) begin
      sendStream($urandom_range(0, 40), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? (SYNC ^ (8'h01 << $urandom_range(0, 7))) : SYNC,
                 $urandom_range(1, 6), $urandom_range(0, 40));
    end
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
